// File: rtl/debounce_sync.sv
// Input conditioning: synchronizes a raw asynchronous level, debounces it with a
// qualification counter, and reports qualified edges plus a saturating glitch count.
module debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic       q,
  output logic       rise,
  output logic       fall,
  output logic       busy,
  output logic [7:0] glitch_cnt
);

  typedef enum logic [1:0] {
    STABLE_LOW,
    QUAL_HIGH,
    STABLE_HIGH,
    QUAL_LOW
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;
  logic [7:0]       glitch_q, glitch_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= STABLE_LOW;
      cnt_q    <= '0;
      q_q      <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      busy_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      busy_q   <= busy_d;
      glitch_q <= glitch_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = glitch_q;

    unique case (state_q)
      STABLE_LOW: begin
        if (s) begin
          cnt_d   = CNT_ONE;
          state_d = QUAL_HIGH;
        end
      end
      QUAL_HIGH: begin
        if (!s) begin
          cnt_d   = '0;
          state_d = STABLE_LOW;
          if (glitch_q != '1) glitch_d = glitch_q + 8'd1;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          q_d     = 1'b1;
          rise_d  = 1'b1;
          state_d = STABLE_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          cnt_d   = CNT_ONE;
          state_d = QUAL_LOW;
        end
      end
      QUAL_LOW: begin
        if (s) begin
          cnt_d   = '0;
          state_d = STABLE_HIGH;
          if (glitch_q != '1) glitch_d = glitch_q + 8'd1;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          q_d     = 1'b0;
          fall_d  = 1'b1;
          state_d = STABLE_LOW;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase

    // busy is registered from the next state so it tracks the qualifying states exactly
    busy_d = (state_d == QUAL_HIGH) || (state_d == QUAL_LOW);
  end

  assign q          = q_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign busy       = busy_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: two instances (default and a small corner
// configuration) driven with the same stimulus and checked against a run-length model.
module tb_debounce_sync;

  localparam int ST0 = 2, DB0 = 4;
  localparam int ST1 = 3, DB1 = 2;

  typedef struct packed {
    logic       q;
    logic       rise;
    logic       fall;
    logic       busy;
    logic [7:0] gl;
  } obs_t;

  logic       clk;
  logic       reset;
  logic       din;
  logic       q0, rise0, fall0, busy0;
  logic [7:0] gl0;
  logic       q1, rise1, fall1, busy1;
  logic [7:0] gl1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  obs_t exp0[$];
  obs_t exp1[$];

  // reference model: input delayed by the synchronizer depth, then a run-length rule
  int   st_m[2];
  int   db_m[2];
  logic [7:0] hist_m[2];
  logic       lvl_m[2];
  int         run_m[2];
  int         gl_m[2];

  debounce_sync #(.SYNC_STAGES(ST0), .DEBOUNCE_CYCLES(DB0)) u_dut0 (
    .clk(clk), .reset(reset), .din(din),
    .q(q0), .rise(rise0), .fall(fall0), .busy(busy0), .glitch_cnt(gl0)
  );

  debounce_sync #(.SYNC_STAGES(ST1), .DEBOUNCE_CYCLES(DB1)) u_dut1 (
    .clk(clk), .reset(reset), .din(din),
    .q(q1), .rise(rise1), .fall(fall1), .busy(busy1), .glitch_cnt(gl1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic obs_t model_reset(input int m);
    obs_t o;
    hist_m[m] = '0;
    lvl_m[m]  = 1'b0;
    run_m[m]  = 0;
    gl_m[m]   = 0;
    o = '0;
    return o;
  endfunction

  function automatic obs_t model_step(input int m, input logic d);
    obs_t o;
    logic s;
    s = hist_m[m][st_m[m]-1];
    hist_m[m] = {hist_m[m][6:0], d};
    o = '0;
    if (s != lvl_m[m]) begin
      run_m[m]++;
      if (run_m[m] == db_m[m]) begin
        lvl_m[m] = s;
        o.rise   = s;
        o.fall   = ~s;
        run_m[m] = 0;
      end
    end else if (run_m[m] > 0) begin
      run_m[m] = 0;
      if (gl_m[m] < 255) gl_m[m]++;
    end
    o.q    = lvl_m[m];
    o.busy = (run_m[m] > 0);
    o.gl   = 8'(gl_m[m]);
    return o;
  endfunction

  task automatic push_reset();
    exp0.push_back(model_reset(0));
    exp1.push_back(model_reset(1));
  endtask

  task automatic cycle(input logic d);
    @(negedge clk);
    reset = 1'b1;
    din   = d;
    exp0.push_back(model_step(0, d));
    exp1.push_back(model_step(1, d));
  endtask

  // asserts reset away from any clock edge and holds it across `hold` rising edges
  task automatic async_reset(input int hold);
    @(negedge clk);
    #2;
    push_reset();
    push_reset();
    reset = 1'b0;
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      push_reset();
    end
  endtask

  task automatic cmp(input string name, input int dut, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t act=%0h exp=%0h", name, dut, $time, act, exp);
    end
  endtask

  task automatic cmp_obs(input int dut, input obs_t act, input obs_t e);
    cmp("q",          dut, {7'd0, act.q},    {7'd0, e.q});
    cmp("rise",       dut, {7'd0, act.rise}, {7'd0, e.rise});
    cmp("fall",       dut, {7'd0, act.fall}, {7'd0, e.fall});
    cmp("busy",       dut, {7'd0, act.busy}, {7'd0, e.busy});
    cmp("glitch_cnt", dut, act.gl,           e.gl);
  endtask

  // monitor: every rising clock edge and every asynchronous reset assertion is an observation
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk or negedge reset);
      #1;
      if (exp0.size() > 0) begin
        e = exp0.pop_front();
        a = '{q: q0, rise: rise0, fall: fall0, busy: busy0, gl: gl0};
        cmp_obs(0, a, e);
      end
      if (exp1.size() > 0) begin
        e = exp1.pop_front();
        a = '{q: q1, rise: rise1, fall: fall1, busy: busy1, gl: gl1};
        cmp_obs(1, a, e);
      end
    end
  end

  initial begin
    int lvl;
    int len;
    st_m[0] = ST0; db_m[0] = DB0;
    st_m[1] = ST1; db_m[1] = DB1;
    reset = 1'b1;
    din   = 1'b0;

    // reset, then a steady rise
    async_reset(2);
    repeat (12) cycle(1'b1);

    // bounce from low
    repeat (12) cycle(1'b0);
    repeat (2) cycle(1'b1);
    repeat (3) cycle(1'b0);
    repeat (2) cycle(1'b1);
    repeat (12) cycle(1'b0);

    // falling edge from a steady high
    repeat (12) cycle(1'b1);
    repeat (12) cycle(1'b0);

    // reset between edges 4 and 5 of a rising qualification, din kept high
    repeat (4) cycle(1'b1);
    async_reset(1);
    repeat (12) cycle(1'b1);
    repeat (12) cycle(1'b0);

    // glitch counter saturation
    async_reset(1);
    repeat (300) begin
      cycle(1'b1);
      repeat (8) cycle(1'b0);
    end

    // randomized runs with occasional asynchronous resets
    async_reset(2);
    lvl = 0;
    repeat (400) begin
      lvl = 1 - lvl;
      len = $urandom_range(1, 7);
      repeat (len) cycle(lvl[0]);
      if ($urandom_range(0, 39) == 0) async_reset($urandom_range(1, 3));
    end
    repeat (12) cycle(1'b0);

    // bounded drain of the scoreboard
    for (int i = 0; i < 20 && (exp0.size() > 0 || exp1.size() > 0); i++) @(posedge clk);
    #3;
    checks++;
    if (exp0.size() > 0 || exp1.size() > 0) begin
      errors++;
      $display("FAIL drain pending0=%0d pending1=%0d exp=0", exp0.size(), exp1.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Input-conditioning stage that sits directly upstream of the team's D flip-flop.
- Takes a raw asynchronous level (switch, button or external pin) and synchronizes it into the clk domain.
- Debounces it with a qualification counter and drives a clean level `q`, intended for the flip-flop's `d` input.
- Also emits single-cycle `rise`/`fall` pulses and a saturating glitch counter for debug.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on `din`; legal range 2..4.
- DEBOUNCE_CYCLES, 4, consecutive synchronized samples at the new level required before `q` changes; legal range 2..65535.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of the qualification counter; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- din  input  1  raw asynchronous input level
- q  output  1  debounced, synchronized level
- rise  output  1  one-cycle pulse on a qualified 0->1 change of q
- fall  output  1  one-cycle pulse on a qualified 1->0 change of q
- busy  output  1  high while a level change is being qualified
- glitch_cnt  output  8  saturating count of aborted qualifications

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - All synchronizer flops = 0; state = STABLE_LOW; counter = 0.
  - q=0, rise=0, fall=0, busy=0, glitch_cnt=0.
  - Reset release takes effect on the next clk rising edge.
- Synchronizer:
  - `din` passes through SYNC_STAGES flops; `s` is the last stage output.
  - The FSM sees only `s`, never `din`.
- FSM states:
  - STABLE_LOW: q=0. If s=1: counter<=1, go QUAL_HIGH. Otherwise hold.
  - QUAL_HIGH: busy=1.
    - If s=0: abort, counter<=0, glitch_cnt+=1 (saturates at 255), go STABLE_LOW.
    - Else if counter==DEBOUNCE_CYCLES-1: q<=1, rise<=1 for that one cycle, counter<=0, go STABLE_HIGH.
    - Else counter<=counter+1.
  - STABLE_HIGH: q=1. If s=0: counter<=1, go QUAL_LOW.
  - QUAL_LOW: mirror of QUAL_HIGH with the levels swapped.
    - Abort on s=1 returns to STABLE_HIGH and increments glitch_cnt.
    - Completion sets q<=0 and pulses fall.
- Latency:
  - Count the first rising edge that samples the new `din` value as edge 1.
  - q, and rise/fall, update on edge SYNC_STAGES+DEBOUNCE_CYCLES. This is edge 6 at defaults.
- Pulse and flag rules:
  - rise and fall are registered, high exactly one cycle, coincident with the cycle q first shows the new value.
  - rise and fall are never high together.
  - busy is registered and high exactly while state is QUAL_HIGH or QUAL_LOW.
- Glitch handling:
  - A pulse on `s` shorter than DEBOUNCE_CYCLES samples never changes q.
  - Each such pulse increments glitch_cnt once.
  - glitch_cnt holds at 255; it is cleared only by reset.
- Reset mid-qualification:
  - Abandons the qualification immediately; q=0.
  - If din is still 1 after release, a full qualification runs and rise pulses. This is the required behaviour, not an error.
- Counter width: the counter never exceeds DEBOUNCE_CYCLES-1; no wrap is possible.

Test Plan:
1. Reset then steady rise: reset=0 for 2 cycles, release, din=1 with setup before an edge.
   -> q=0 through edge 5; q=1 and rise=1 after edge 6; rise=0 after edge 7; busy=1 after edges 3..5; glitch_cnt=0.
2. Bounce: from q=0, din high for 2 cycles, low 3 cycles, high 2 cycles, then low.
   -> q stays 0, rise never asserts, glitch_cnt=2.
3. Falling edge: from q=1 steady, din=0.
   -> q=0 and fall=1 after edge 6; fall high exactly one cycle; rise stays 0.
4. Reset mid-operation: din=1, assert reset=0 asynchronously between edges 4 and 5.
   -> q, busy, glitch_cnt drop to 0 immediately without a clock edge; after release with din=1, q=1 on edge 6 post-release.
5. Saturation: 300 isolated 1-cycle high pulses on din, each separated by 8 low cycles.
   -> glitch_cnt=255 and holds; q=0 throughout.
6. Parameter corner: SYNC_STAGES=3, DEBOUNCE_CYCLES=2, din=1.
   -> q=1 and rise=1 after edge 5; a 1-sample glitch increments glitch_cnt by 1.
